// File: rtl/alu_mc_flags_if.sv
// Operand and result handshake bundle for alu_mc_flags.
// master: issues ops and takes results; slave: the ALU.
interface alu_mc_flags_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Aluop;
  logic [W-1:0] DatA;
  logic [W-1:0] DatB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Rslt;
  logic         SCo;
  logic         Zero;
  logic         LessThan;
  logic         AddFlag;
  logic         busy;

  modport master (
    output in_valid, Aluop, DatA, DatB, out_ready,
    input  in_ready, out_valid, Rslt,
    input  SCo, Zero, LessThan, AddFlag, busy
  );

  modport slave (
    input  in_valid, Aluop, DatA, DatB, out_ready,
    output in_ready, out_valid, Rslt,
    output SCo, Zero, LessThan, AddFlag, busy
  );
endinterface

// File: rtl/alu_mc_flags.sv
// Multi-cycle ALU with persistent SCo/Zero/LessThan/AddFlag state.
// Ports: Clk, Reset (async, active high), bus (slave handshake bundle).
module alu_mc_flags #(
  parameter int W   = 8,
  parameter int SAW = $clog2(W) + 1
) (
  input logic           Clk,
  input logic           Reset,
  alu_mc_flags_if.slave bus
);
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_LSL  = 4'd4;
  localparam logic [3:0] OP_LSR  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_SCMP = 4'd8;
  localparam logic [3:0] OP_BR   = 4'd9;
  localparam logic [3:0] OP_MOVI = 4'd10;
  localparam logic [3:0] OP_ADC  = 4'd11;
  localparam logic [3:0] OP_RADD = 4'd12;
  localparam logic [3:0] OP_ADF  = 4'd13;
  localparam logic [3:0] OP_ST   = 4'd14;
  localparam logic [3:0] OP_LD   = 4'd15;

  localparam logic [SAW-1:0] WN = SAW'(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_COMMIT
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [SAW-1:0] cnt_q, cnt_d;
  logic           lb_q, lb_d;
  logic           nz_q, nz_d;
  logic           over_q, over_d;
  logic [W-1:0]   rslt_q, rslt_d;
  logic           sco_q, sco_d;
  logic           zero_q, zero_d;
  logic           lt_q, lt_d;
  logic           af_q, af_d;
  logic           ov_q, ov_d;

  logic           in_rdy;
  logic [SAW-1:0] n;
  logic [W:0]     add_r, adc_r, sub_r;
  logic [W-1:0]   lsl_r;
  logic           lastout;

  assign in_rdy = !Reset && (state_q == S_IDLE)
                  && (!ov_q || bus.out_ready);
  assign n      = bus.DatB[SAW-1:0];

  assign add_r = {1'b0, a_q} + {1'b0, b_q};
  assign adc_r = add_r + {{W{1'b0}}, sco_q};
  assign sub_r = {1'b0, a_q} - {1'b0, b_q};
  // carry-in add applied after the shift, using the pre-op carry
  assign lsl_r = a_q + {{(W-1){1'b0}}, sco_q};
  // shifting past W bits would have pushed out only zeros
  assign lastout = over_q ? 1'b0 : lb_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    lb_d    = lb_q;
    nz_d    = nz_q;
    over_d  = over_q;
    rslt_d  = rslt_q;
    sco_d   = sco_q;
    zero_d  = zero_q;
    lt_d    = lt_q;
    af_d    = af_q;
    ov_d    = ov_q;
    if (ov_q && bus.out_ready) ov_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_rdy) begin
          op_d   = bus.Aluop;
          a_d    = bus.DatA;
          b_d    = bus.DatB;
          nz_d   = (n != '0);
          over_d = (n > WN);
          cnt_d  = (n > WN) ? WN : n;
          lb_d   = 1'b0;
          state_d = S_COMMIT;
          if (bus.Aluop == OP_RADD) begin
            // bit 0 is counted on the accept edge
            a_d     = {{(W-1){1'b0}}, bus.DatB[0]};
            b_d     = bus.DatB >> 1;
            cnt_d   = SAW'(W - 1);
            state_d = S_ITER;
          end else if ((bus.Aluop == OP_LSL ||
                        bus.Aluop == OP_LSR) && n != '0) begin
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        cnt_d = cnt_q - SAW'(1);
        if (op_q == OP_LSL) begin
          a_d  = a_q << 1;
          lb_d = a_q[W-1];
        end else if (op_q == OP_LSR) begin
          a_d  = a_q >> 1;
          lb_d = a_q[0];
        end else begin
          a_d = a_q + {{(W-1){1'b0}}, b_q[0]};
          b_d = b_q >> 1;
        end
        if (cnt_q == SAW'(1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        ov_d    = 1'b1;
        unique case (1'b1)
          (op_q == OP_NOP || op_q == OP_BR): rslt_d = {{(W-1){1'b0}}, 1'b1};
          (op_q == OP_ADD): {sco_d, rslt_d} = add_r;
          (op_q == OP_NOT): rslt_d = ~b_q;
          (op_q == OP_XOR): rslt_d = a_q ^ b_q;
          (op_q == OP_LSL): begin
            rslt_d = lsl_r;
            if (nz_q) sco_d = lastout;
          end
          (op_q == OP_LSR): begin
            rslt_d = a_q;
            if (nz_q) af_d = lastout;
          end
          (op_q == OP_MOV): rslt_d = a_q;
          (op_q == OP_CMP): begin
            {lt_d, rslt_d} = sub_r;
            zero_d = (a_q == b_q);
          end
          (op_q == OP_SCMP): begin
            rslt_d = sub_r[W-1:0];
            lt_d   = ($signed(a_q) < $signed(b_q));
            zero_d = (a_q == b_q);
          end
          (op_q == OP_MOVI): rslt_d = b_q;
          (op_q == OP_ADC):  {sco_d, rslt_d} = adc_r;
          (op_q == OP_RADD): rslt_d = a_q;
          (op_q == OP_ADF): begin
            if (af_q) {sco_d, rslt_d} = adc_r;
            else      rslt_d = a_q;
          end
          (op_q == OP_ST || op_q == OP_LD): rslt_d = add_r[W-1:0];
          default: rslt_d = rslt_q;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      lb_q    <= 1'b0;
      nz_q    <= 1'b0;
      over_q  <= 1'b0;
      rslt_q  <= '0;
      sco_q   <= 1'b0;
      zero_q  <= 1'b0;
      lt_q    <= 1'b0;
      af_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      lb_q    <= lb_d;
      nz_q    <= nz_d;
      over_q  <= over_d;
      rslt_q  <= rslt_d;
      sco_q   <= sco_d;
      zero_q  <= zero_d;
      lt_q    <= lt_d;
      af_q    <= af_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ov_q;
  assign bus.Rslt      = rslt_q;
  assign bus.SCo       = sco_q;
  assign bus.Zero      = zero_q;
  assign bus.LessThan  = lt_q;
  assign bus.AddFlag   = af_q;
  assign bus.busy      = (state_q == S_ITER);
endmodule

// File: tb/tb_alu_mc_flags.sv
// Directed bench for alu_mc_flags at W=8.
// Flags are checked as {SCo, Zero, LessThan, AddFlag}.
module tb_alu_mc_flags;
  logic Clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clk = ~Clk;

  alu_mc_flags_if #(.W(8)) bus ();

  alu_mc_flags #(.W(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.SCo, bus.Zero, bus.LessThan, bus.AddFlag};
  endfunction

  task automatic issue(input logic [3:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       output int bz);
    int g;
    bus.Aluop    = op;
    bus.DatA     = a;
    bus.DatB     = b;
    bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge Clk); #1;
      g++;
    end
    if (g == 50) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    bz = int'(bus.busy);
  endtask

  task automatic wait_out(output int lat, inout int bz);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      lat++;
      bz += int'(bus.busy);
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) chk("out_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic run(input string tag,
                     input logic [3:0] op,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [7:0] er,
                     input logic [3:0] ef,
                     input int el);
    int bz, lat;
    issue(op, a, b, bz);
    wait_out(lat, bz);
    chk({tag, ".rslt"}, 32'(bus.Rslt), 32'(er));
    chk({tag, ".flags"}, 32'(flags()), 32'(ef));
    chk({tag, ".lat"}, lat, el);
    chk({tag, ".busy"}, bz, (el > 1) ? el - 1 : 0);
  endtask

  initial begin
    int bz, lat, stale;
    logic [7:0] got[$];

    Reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.Aluop     = '0;
    bus.DatA      = '0;
    bus.DatB      = '0;
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 0);
    chk("rst.rslt", 32'(bus.Rslt), 0);
    chk("rst.flags", 32'(flags()), 0);
    chk("rst.out_valid", 32'(bus.out_valid), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    #1 chk("rel.in_ready", 32'(bus.in_ready), 1);

    run("add",    4'd1,  8'hF0, 8'h20, 8'h10, 4'b1000, 1);
    run("adc",    4'd11, 8'h01, 8'h01, 8'h03, 4'b0000, 1);
    run("lsr3",   4'd5,  8'h0B, 8'd3,  8'h01, 4'b0000, 4);
    run("lsr1",   4'd5,  8'h0B, 8'd1,  8'h05, 4'b0001, 2);
    run("cmp_lt", 4'd7,  8'h05, 8'h09, 8'hFC, 4'b0011, 1);
    run("scmp",   4'd8,  8'h80, 8'h01, 8'h7F, 4'b0011, 1);
    run("cmp_eq", 4'd7,  8'h07, 8'h07, 8'h00, 4'b0101, 1);
    run("add_c",  4'd1,  8'hFF, 8'h01, 8'h00, 4'b1101, 1);
    run("lsl1",   4'd4,  8'h81, 8'd1,  8'h03, 4'b1101, 2);
    run("lsl2",   4'd4,  8'h40, 8'd2,  8'h01, 4'b1101, 3);
    run("lsl0",   4'd4,  8'h05, 8'd0,  8'h06, 4'b1101, 1);
    run("lsl8",   4'd4,  8'h01, 8'd8,  8'h01, 4'b1101, 9);
    run("lsl9",   4'd4,  8'hFF, 8'd9,  8'h01, 4'b0101, 9);
    run("lsr_a",  4'd5,  8'h02, 8'd1,  8'h01, 4'b0100, 2);
    run("lsr8",   4'd5,  8'h80, 8'd8,  8'h00, 4'b0101, 9);
    run("lsr9",   4'd5,  8'h80, 8'd9,  8'h00, 4'b0100, 9);
    run("lsr0",   4'd5,  8'h0F, 8'd0,  8'h0F, 4'b0100, 1);
    run("lsr_b",  4'd5,  8'h01, 8'd1,  8'h00, 4'b0101, 2);
    run("adf1",   4'd13, 8'h10, 8'h20, 8'h30, 4'b0101, 1);
    run("add_d",  4'd1,  8'h80, 8'h80, 8'h00, 4'b1101, 1);
    run("adf1c",  4'd13, 8'h10, 8'h20, 8'h31, 4'b0101, 1);
    run("lsr_c",  4'd5,  8'h02, 8'd1,  8'h01, 4'b0100, 2);
    run("add_e",  4'd1,  8'h80, 8'h80, 8'h00, 4'b1100, 1);
    run("adf0",   4'd13, 8'h33, 8'h44, 8'h33, 4'b1100, 1);
    run("nop",    4'd0,  8'h55, 8'h66, 8'h01, 4'b1100, 1);
    run("br",     4'd9,  8'h55, 8'h66, 8'h01, 4'b1100, 1);
    run("not",    4'd2,  8'h00, 8'h0F, 8'hF0, 4'b1100, 1);
    run("xor",    4'd3,  8'hF0, 8'h3C, 8'hCC, 4'b1100, 1);
    run("mov",    4'd6,  8'h5A, 8'h00, 8'h5A, 4'b1100, 1);
    run("movi",   4'd10, 8'h00, 8'hA5, 8'hA5, 4'b1100, 1);
    run("st",     4'd14, 8'h80, 8'h90, 8'h10, 4'b1100, 1);
    run("ld",     4'd15, 8'h01, 8'h02, 8'h03, 4'b1100, 1);
    run("adc_c",  4'd11, 8'h01, 8'h01, 8'h03, 4'b0100, 1);
    run("scmp_p", 4'd8,  8'h01, 8'h80, 8'h81, 4'b0000, 1);
    run("cmp_eq2",4'd7,  8'h03, 8'h03, 8'h00, 4'b0100, 1);

    // RADD with a stalled consumer
    @(posedge Clk); #1;
    bus.out_ready = 1'b0;
    issue(4'd12, 8'h00, 8'hB7, bz);
    wait_out(lat, bz);
    chk("radd.rslt", 32'(bus.Rslt), 6);
    chk("radd.lat", lat, 8);
    chk("radd.busy", bz, 7);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("hold.out_valid", 32'(bus.out_valid), 1);
      chk("hold.rslt", 32'(bus.Rslt), 6);
      chk("hold.in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1 chk("hand.in_ready", 32'(bus.in_ready), 1);
    @(posedge Clk); #1;
    chk("hand.out_valid", 32'(bus.out_valid), 0);

    // reset in the middle of an LSL
    issue(4'd4, 8'hFF, 8'd5, bz);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("mid.busy", 32'(bus.busy), 1);
    Reset = 1'b1;
    #1;
    chk("arst.rslt", 32'(bus.Rslt), 0);
    chk("arst.flags", 32'(flags()), 0);
    chk("arst.out_valid", 32'(bus.out_valid), 0);
    chk("arst.busy", 32'(bus.busy), 0);
    chk("arst.in_ready", 32'(bus.in_ready), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1 chk("arel.in_ready", 32'(bus.in_ready), 1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      stale |= int'(bus.out_valid);
    end
    chk("arel.stale", stale, 0);

    // back-to-back MOVI stream
    fork
      begin
        for (int k = 1; k <= 3; k++) begin
          int g;
          bus.Aluop    = 4'd10;
          bus.DatA     = 8'h00;
          bus.DatB     = 8'(k);
          bus.in_valid = 1'b1;
          g = 0;
          while (!bus.in_ready && g < 20) begin
            @(posedge Clk); #1;
            g++;
          end
          @(posedge Clk); #1;
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(posedge Clk); #1;
          if (bus.out_valid) got.push_back(bus.Rslt);
        end
      end
    join
    chk("b2b.count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] v;
      v = (i < got.size()) ? got[i] : 8'hxx;
      chk("b2b.rslt", 32'(v), i + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
